// File: rtl/counter_pkg.sv
// Shared types and constants for the counter/timing library.
// The down counter's FSM states and their encodings live here.
package counter_pkg;

    localparam int STATE_BITS   = 2;
    localparam int MIN_WIDTH    = 2;
    localparam int MIN_PRESCALE = 1;

    localparam logic [STATE_BITS-1:0] ENC_IDLE    = 2'd0;
    localparam logic [STATE_BITS-1:0] ENC_COUNT   = 2'd1;
    localparam logic [STATE_BITS-1:0] ENC_EXPIRED = 2'd2;

    typedef enum logic [STATE_BITS-1:0] {
        IDLE    = ENC_IDLE,
        COUNT   = ENC_COUNT,
        EXPIRED = ENC_EXPIRED
    } state_t;

endpackage

// File: rtl/down_counter_prescaler.sv
// Modulo-PRESCALE enabled tick generator for the down counter.
// Only compiled when DOWN_COUNTER_PRESCALE_EN is defined.
`ifdef DOWN_COUNTER_PRESCALE_EN
module down_counter_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clock,
    input  logic clear_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_count;

    assign o_tick = i_enable && (r_count == LAST);

    // Wrapping on the tick doubles as the clear-on-decrement.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= (r_count == LAST) ? '0 : r_count + CW'(1);
        end
    end

endmodule
`endif

// File: rtl/down_counter.sv
// Loadable down counter / countdown timer with one-shot or wrap (auto-reload) mode.
// Define DOWN_COUNTER_PRESCALE_EN to add a PRESCALE divider on the enabled count.
module down_counter #(
    parameter int WIDTH = 4,
    parameter int WRAP  = 0
`ifdef DOWN_COUNTER_PRESCALE_EN
    ,
    parameter int PRESCALE = 4
`endif
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             expired,
    output logic             done
);

    import counter_pkg::*;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_done;
    logic             r_busy;
    logic             r_expired;

    state_t           w_nextState;
    logic [WIDTH-1:0] w_nextCount;
    logic [WIDTH-1:0] w_nextReload;
    logic             w_nextDone;
    logic             w_tick;

`ifdef DOWN_COUNTER_PRESCALE_EN
    logic w_prescaleEnable;

    assign w_prescaleEnable = enable && (r_state == COUNT) && !start;

    down_counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock    (clock),
        .clear_n  (clear_n),
        .i_clear  (start),
        .i_enable (w_prescaleEnable),
        .o_tick   (w_tick)
    );
`else
    assign w_tick = enable;
`endif

    // start wins over everything; a zero load expires immediately.
    always_comb begin
        w_nextState  = r_state;
        w_nextCount  = r_count;
        w_nextReload = r_reload;
        w_nextDone   = 1'b0;
        if (start) begin
            w_nextCount  = load_value;
            w_nextReload = load_value;
            if (load_value == '0) begin
                w_nextState = EXPIRED;
                w_nextDone  = 1'b1;
            end else begin
                w_nextState = COUNT;
            end
        end else begin
            case (r_state)
                COUNT: begin
                    if (w_tick) begin
                        if (r_count > WIDTH'(1)) begin
                            w_nextCount = r_count - WIDTH'(1);
                        end else if (WRAP != 0) begin
                            w_nextCount = r_reload;
                            w_nextDone  = 1'b1;
                        end else begin
                            w_nextCount = '0;
                            w_nextState = EXPIRED;
                            w_nextDone  = 1'b1;
                        end
                    end
                end
                EXPIRED: begin
                    w_nextCount = '0;
                end
                default: begin
                    w_nextState = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_reload  <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_count   <= w_nextCount;
            r_reload  <= w_nextReload;
            r_done    <= w_nextDone;
            r_busy    <= (w_nextState == COUNT);
            r_expired <= (w_nextState == EXPIRED);
        end
    end

    assign Q       = r_count;
    assign busy    = r_busy;
    assign expired = r_expired;
    assign done    = r_done;

endmodule

// File: tb/tb_down_counter.sv
// Directed bench for down_counter: one one-shot instance and one wrap instance.
module tb_down_counter;

    localparam int WIDTH = 4;

    logic             clock;
    logic             clear_n;
    logic             start0, start1;
    logic [WIDTH-1:0] load0, load1;
    logic             enable0, enable1;
    logic [WIDTH-1:0] q0, q1;
    logic             busy0, busy1;
    logic             expired0, expired1;
    logic             done0, done1;

    int vectors;
    int miscompares;

    down_counter #(.WIDTH(WIDTH), .WRAP(0)) dut0 (
        .clock      (clock),
        .clear_n    (clear_n),
        .start      (start0),
        .load_value (load0),
        .enable     (enable0),
        .Q          (q0),
        .busy       (busy0),
        .expired    (expired0),
        .done       (done0)
    );

    down_counter #(.WIDTH(WIDTH), .WRAP(1)) dut1 (
        .clock      (clock),
        .clear_n    (clear_n),
        .start      (start1),
        .load_value (load1),
        .enable     (enable1),
        .Q          (q1),
        .busy       (busy1),
        .expired    (expired1),
        .done       (done1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkAll0(input string tag, input int eq, input int eb, input int ee, input int ed);
        checkOutput({tag, ".Q"}, 32'(q0), 32'(eq));
        checkOutput({tag, ".busy"}, 32'(busy0), 32'(eb));
        checkOutput({tag, ".expired"}, 32'(expired0), 32'(ee));
        checkOutput({tag, ".done"}, 32'(done0), 32'(ed));
    endtask

    initial begin
        int wrapQ[6];
        int wrapD[6];
        wrapQ = '{2, 1, 3, 2, 1, 3};
        wrapD = '{0, 0, 1, 0, 0, 1};
        vectors = 0;
        miscompares = 0;
        clear_n = 1'b0;
        start0 = 1'b0; load0 = '0; enable0 = 1'b0;
        start1 = 1'b0; load1 = '0; enable1 = 1'b0;

        applyStimulus();
        applyStimulus();
        checkAll0("reset", 0, 0, 0, 0);
        clear_n = 1'b1;
        enable0 = 1'b1;
        applyStimulus();
        applyStimulus();
        checkAll0("idle_enable", 0, 0, 0, 0);

        // One-shot load 3 with start and enable together: no decrement on start.
        load0 = 4'd3; start0 = 1'b1; enable0 = 1'b1;
        applyStimulus();
        checkAll0("os_start", 3, 1, 0, 0);
        start0 = 1'b0;
        applyStimulus();
        checkAll0("os_q2", 2, 1, 0, 0);
        applyStimulus();
        checkAll0("os_q1", 1, 1, 0, 0);
        applyStimulus();
        checkAll0("os_q0", 0, 0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            checkAll0("os_hold", 0, 0, 1, 0);
        end

        // Pause with enable low, then restart mid-count.
        load0 = 4'd6; start0 = 1'b1;
        applyStimulus();
        checkAll0("pz_start", 6, 1, 0, 0);
        start0 = 1'b0;
        applyStimulus();
        checkAll0("pz_q5", 5, 1, 0, 0);
        enable0 = 1'b0;
        applyStimulus();
        checkAll0("pz_hold1", 5, 1, 0, 0);
        applyStimulus();
        checkAll0("pz_hold2", 5, 1, 0, 0);
        enable0 = 1'b1;
        applyStimulus();
        checkAll0("pz_q4", 4, 1, 0, 0);
        load0 = 4'd2; start0 = 1'b1;
        applyStimulus();
        checkAll0("rs_start", 2, 1, 0, 0);
        start0 = 1'b0;
        applyStimulus();
        checkAll0("rs_q1", 1, 1, 0, 0);
        enable0 = 1'b0;
        applyStimulus();
        checkAll0("rs_hold", 1, 1, 0, 0);
        enable0 = 1'b1;
        applyStimulus();
        checkAll0("rs_q0", 0, 0, 1, 1);

        // Zero load expires immediately.
        load0 = 4'd0; start0 = 1'b1;
        applyStimulus();
        checkAll0("zero_start", 0, 0, 1, 1);
        start0 = 1'b0;
        applyStimulus();
        checkAll0("zero_after", 0, 0, 1, 0);

        // Asynchronous reset in the middle of a count at Q=5.
        load0 = 4'd7; start0 = 1'b1;
        applyStimulus();
        start0 = 1'b0;
        applyStimulus();
        applyStimulus();
        checkAll0("pre_reset", 5, 1, 0, 0);
        clear_n = 1'b0;
        #1;
        checkAll0("async_reset", 0, 0, 0, 0);
        applyStimulus();
        checkAll0("reset_held", 0, 0, 0, 0);
        clear_n = 1'b1;
        applyStimulus();
        applyStimulus();
        checkAll0("post_reset_idle", 0, 0, 0, 0);

        // Wrap instance: load 3 repeats 3,2,1 with done on each reload.
        load1 = 4'd3; start1 = 1'b1; enable1 = 1'b1;
        applyStimulus();
        checkOutput("wr_start.Q", 32'(q1), 32'd3);
        checkOutput("wr_start.done", 32'(done1), 32'd0);
        start1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            checkOutput("wr_seq.Q", 32'(q1), 32'(wrapQ[i]));
            checkOutput("wr_seq.done", 32'(done1), 32'(wrapD[i]));
            checkOutput("wr_seq.busy", 32'(busy1), 32'd1);
            checkOutput("wr_seq.expired", 32'(expired1), 32'd0);
        end
        enable1 = 1'b0;
        applyStimulus();
        checkOutput("wr_pause.Q", 32'(q1), 32'd3);
        checkOutput("wr_pause.done", 32'(done1), 32'd0);

        // Reload of 1 pulses done on every enabled cycle.
        load1 = 4'd1; start1 = 1'b1; enable1 = 1'b1;
        applyStimulus();
        checkOutput("wr1_start.Q", 32'(q1), 32'd1);
        checkOutput("wr1_start.done", 32'(done1), 32'd0);
        start1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("wr1_seq.Q", 32'(q1), 32'd1);
            checkOutput("wr1_seq.done", 32'(done1), 32'd1);
            checkOutput("wr1_seq.busy", 32'(busy1), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
